mix_word_tx: RTL and testbench

Upstream feeder for the MIX serial character transmitter. Accepts full MIX words (sign plus five 6-bit bytes) from the I/O controller through a valid/ready handshake and buffers them in a small FIFO. Each word is unpacked into five MIX character codes, most significant byte first, and presented one at a time on the transmitter's `load`/`in`/`ready` interface. Words are grouped into device blocks (line printer = 24 words), and block completion is reported.

---
 rtl/mix_word_tx_if.sv | 37 +++
 rtl/mix_word_tx.sv | 180 ++++++++++++++++++
 tb/tb_mix_word_tx.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mix_word_tx_if.sv
// mix_word_tx_if
//   Bundles the word-side valid/ready handshake and the character-side
//   load/ready handshake of the MIX word feeder into one interface.
//
//   Signals:
//     word_in    [30:0] : sign (bit 30, unused) + five 6-bit MIX bytes
//     word_valid        : word_in is valid
//     word_ready        : feeder can accept a word this cycle
//     tx_load           : a character is pending for the transmitter
//     tx_char    [5:0]  : MIX character code
//     tx_ready          : transmitter idle
//     busy              : feeder holds or is sending data
//     block_done        : one-cycle pulse at end of a device block
//
//   Modports:
//     master : the environment (word source + transmitter side)
//     slave  : the mix_word_tx feeder itself
interface mix_word_tx_if;
  logic [30:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        tx_load;
  logic [5:0]  tx_char;
  logic        tx_ready;
  logic        busy;
  logic        block_done;

  modport master (
    output word_in, word_valid, tx_ready,
    input  word_ready, tx_load, tx_char, busy, block_done
  );

  modport slave (
    input  word_in, word_valid, tx_ready,
    output word_ready, tx_load, tx_char, busy, block_done
  );
endinterface

// File: rtl/mix_word_tx.sv
// mix_word_tx
//   Upstream feeder for the MIX serial character transmitter. Buffers MIX
//   words in a small FIFO, unpacks each into five 6-bit character codes
//   (most significant byte first) and hands them one at a time to the
//   transmitter. Words are counted into device blocks; completion of a
//   block is flagged with a one-cycle block_done pulse.
//
//   Parameters:
//     BLOCK_WORDS : words per device block (1..63)
//     FIFO_DEPTH  : word FIFO entries (power of two, 2..16)
//
//   Ports:
//     clk   : system clock, all state on the rising edge
//     reset : synchronous, active-high reset
//     bus   : mix_word_tx_if.slave (word handshake, char handshake, status)
//
//   Configuration macro:
//     MIX_WORD_TX_EOL_EN : when defined, CR (code 20) and LF (code 10) are
//                          sent after every block and block_done follows
//                          the LF hand-off.
module mix_word_tx #(
  parameter int BLOCK_WORDS = 24,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         reset,
  mix_word_tx_if.slave bus
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [5:0]  LAST_WORD  = 6'(BLOCK_WORDS - 1);
`ifdef MIX_WORD_TX_EOL_EN
  localparam logic [5:0]  CHAR_CR    = 6'd20;
  localparam logic [5:0]  CHAR_LF    = 6'd10;
`endif

`ifdef MIX_WORD_TX_EOL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_EOL_CR, ST_EOL_LF} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_SEND} state_t;
`endif

  // Word storage drops the sign bit; it never reaches the line.
  logic [29:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  state_t        state_q, state_d;
  logic [29:0]   shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic [5:0]    wcnt_q, wcnt_d;
  logic          done_q, done_d;

  logic          ready_w;
  logic          push;
  logic          pop;
  logic          load_w;
  logic [5:0]    char_w;
  logic          unused_sign;

  assign unused_sign = bus.word_in[30];

  // Gated by reset so the source sees "not ready" for the whole reset.
  assign ready_w = !reset && (count_q != FULL_COUNT);
  assign push    = bus.word_valid && ready_w;
  assign pop     = (state_q == ST_IDLE) && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.word_in[29:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    done_d   = 1'b0;
    load_w   = 1'b0;
    char_w   = '0;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          shift_d = fifo_mem[rd_ptr_q];
          idx_d   = 3'd0;
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        load_w = 1'b1;
        char_w = shift_q[29:24];
        // load is high here, so tx_ready alone marks the hand-off edge.
        if (bus.tx_ready) begin
          shift_d = {shift_q[23:0], 6'd0};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd4) begin
            idx_d = 3'd0;
            if (wcnt_q == LAST_WORD) begin
              wcnt_d = 6'd0;
`ifdef MIX_WORD_TX_EOL_EN
              state_d = ST_EOL_CR;
`else
              state_d = ST_IDLE;
              done_d  = 1'b1;
`endif
            end else begin
              wcnt_d  = wcnt_q + 6'd1;
              state_d = ST_IDLE;
            end
          end
        end
      end

`ifdef MIX_WORD_TX_EOL_EN
      ST_EOL_CR: begin
        load_w = 1'b1;
        char_w = CHAR_CR;
        if (bus.tx_ready) begin
          state_d = ST_EOL_LF;
        end
      end

      ST_EOL_LF: begin
        load_w = 1'b1;
        char_w = CHAR_LF;
        if (bus.tx_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      wcnt_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      done_q   <= done_d;
    end
  end

  assign bus.word_ready = ready_w;
  assign bus.tx_load    = load_w;
  assign bus.tx_char    = char_w;
  assign bus.busy       = (count_q != '0) || (state_q != ST_IDLE);
  assign bus.block_done = done_q;

endmodule

// File: tb/tb_mix_word_tx.sv
// tb_mix_word_tx
//   Directed, table-driven bench for mix_word_tx (BLOCK_WORDS = 2,
//   FIFO_DEPTH = 4). A negedge process models the transmitter's ready line
//   (held low, frame-gap model, or random) and logs every hand-off and
//   every block_done pulse with its cycle number.
`timescale 1ns/1ps
module tb_mix_word_tx;
  localparam int BW  = 2;
  localparam int FD  = 4;
  localparam int GAP = 3;
`ifdef MIX_WORD_TX_EOL_EN
  localparam bit EOL = 1'b1;
`else
  localparam bit EOL = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mix_word_tx_if bus_if ();

  mix_word_tx #(.BLOCK_WORDS(BW), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct packed {
    logic [30:0]      word;
    logic [0:4][5:0]  ch;
  } vec_t;

  vec_t       vecs [6];
  int         total = 0;
  int         bad   = 0;
  int         mode  = 0;     // 0: ready low, 1: frame gap model, 2: random
  int         gap_cnt = 0;
  int         cyc   = 0;
  logic [5:0] rx_q [$];
  int         rx_cyc [$];
  int         bd_cyc [$];
  logic [5:0] exp_q [$];
  int         last_q [$];
  logic       prev_stall = 1'b0;
  logic [5:0] prev_char  = '0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transmitter model and observer, all on the falling edge.
  always @(negedge clk) begin
    logic r;
    cyc++;
    case (mode)
      1:       r = (gap_cnt == 0);
      2:       r = ($urandom_range(0, 1) != 0);
      default: r = 1'b0;
    endcase
    if (gap_cnt > 0) gap_cnt--;
    bus_if.tx_ready = r;
    if (prev_stall && bus_if.tx_load)
      check("stall_hold", int'(bus_if.tx_char), int'(prev_char));
    if (bus_if.tx_load && r) begin
      rx_q.push_back(bus_if.tx_char);
      rx_cyc.push_back(cyc);
      gap_cnt = GAP;
      $display("handoff char=%0d cyc=%0d", bus_if.tx_char, cyc);
    end
    if (bus_if.block_done) begin
      bd_cyc.push_back(cyc);
      $display("block_done cyc=%0d", cyc);
    end
    prev_stall = bus_if.tx_load && !r;
    prev_char  = bus_if.tx_char;
  end

  task automatic clear_rx();
    rx_q.delete();
    rx_cyc.delete();
    bd_cyc.delete();
  endtask

  task automatic push_word(input logic [30:0] w, input int budget, output bit ok);
    ok = 1'b0;
    bus_if.word_in    = w;
    bus_if.word_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (bus_if.word_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus_if.word_valid = 1'b0;
    $display("push word=%o accepted=%0d", w, ok);
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int i = 0;
    while (rx_q.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, (rx_q.size() >= n) ? n : rx_q.size(), n);
  endtask

  // Expected character stream for vectors first..last, starting with wc0
  // words already counted in the current block.
  task automatic build_exp(input int first, input int last, input int wc0);
    int wc = wc0;
    exp_q.delete();
    last_q.delete();
    for (int v = first; v <= last; v++) begin
      for (int c = 0; c < 5; c++) exp_q.push_back(vecs[v].ch[c]);
      wc++;
      if (wc == BW) begin
        wc = 0;
        if (EOL) begin
          exp_q.push_back(6'd20);
          exp_q.push_back(6'd10);
        end
        last_q.push_back(exp_q.size() - 1);
      end
    end
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_char%0d", tag, i), int'(rx_q[i]), int'(exp_q[i]));
    check({tag, "_bd_count"}, bd_cyc.size(), last_q.size());
    for (int j = 0; j < last_q.size() && j < bd_cyc.size(); j++)
      if (last_q[j] < rx_cyc.size())
        check($sformatf("%s_bd_time%0d", tag, j), bd_cyc[j], rx_cyc[last_q[j]] + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    bit ok;
    vecs[0] = '{word: {1'b0, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5},  ch: {6'd1,  6'd2,  6'd3,  6'd4,  6'd5}};
    vecs[1] = '{word: {1'b1, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5},  ch: {6'd1,  6'd2,  6'd3,  6'd4,  6'd5}};
    vecs[2] = '{word: {1'b0, 6'd30, 6'd31, 6'd32, 6'd33, 6'd34}, ch: {6'd30, 6'd31, 6'd32, 6'd33, 6'd34}};
    vecs[3] = '{word: {1'b0, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39}, ch: {6'd35, 6'd36, 6'd37, 6'd38, 6'd39}};
    vecs[4] = '{word: {1'b0, 6'd63, 6'd56, 6'd0,  6'd7,  6'd60}, ch: {6'd63, 6'd56, 6'd0,  6'd7,  6'd60}};
    vecs[5] = '{word: {1'b1, 6'd21, 6'd42, 6'd63, 6'd0,  6'd1},  ch: {6'd21, 6'd42, 6'd63, 6'd0,  6'd1}};

    bus_if.word_in    = '0;
    bus_if.word_valid = 1'b0;
    reset = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_word_ready", bus_if.word_ready, 0);
    check("rst_tx_load",    bus_if.tx_load,    0);
    check("rst_tx_char",    bus_if.tx_char,    0);
    check("rst_busy",       bus_if.busy,       0);
    check("rst_block_done", bus_if.block_done, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_word_ready", bus_if.word_ready, 1);

    // Single word: latency and char order, no block_done (1 of 2 words)
    mode = 1;
    clear_rx();
    push_word(vecs[0].word, 5, ok);
    check("lat_accept", ok, 1);
    check("lat_idle_load", bus_if.tx_load, 0);
    check("lat_busy", bus_if.busy, 1);
    @(negedge clk);
    check("lat_load", bus_if.tx_load, 1);
    check("lat_char", bus_if.tx_char, 1);
    wait_rx(5, 200, "single_wait");
    repeat (3) @(negedge clk);
    check("single_busy", bus_if.busy, 0);
    build_exp(0, 0, 0);
    check_rx("single");

    // Table: remaining vectors, completing three blocks
    clear_rx();
    for (int v = 1; v < 6; v++) begin
      push_word(vecs[v].word, 500, ok);
      check($sformatf("tbl_accept%0d", v), ok, 1);
    end
    build_exp(1, 5, 1);
    wait_rx(exp_q.size(), 2000, "tbl_wait");
    repeat (4) @(negedge clk);
    check_rx("tbl");

    // Backpressure: FIFO plus the word held in the unpacker = 5 words
    mode = 0;
    repeat (6) @(negedge clk);
    clear_rx();
    for (int v = 0; v < 5; v++) begin
      push_word(vecs[v].word, 3, ok);
      check($sformatf("bp_accept%0d", v), ok, 1);
    end
    push_word(vecs[5].word, 10, ok);
    check("bp_full_reject", ok, 0);
    check("bp_word_ready", bus_if.word_ready, 0);
    check("bp_load", bus_if.tx_load, 1);
    check("bp_char", bus_if.tx_char, 1);
    mode = 2;
    push_word(vecs[5].word, 3000, ok);
    check("bp_late_accept", ok, 1);
    build_exp(0, 5, 0);
    wait_rx(exp_q.size(), 5000, "bp_wait");
    repeat (4) @(negedge clk);
    check_rx("bp");

    // Reset after the 3rd char of the 2nd word of a block
    mode = 1;
    repeat (6) @(negedge clk);
    clear_rx();
    push_word(vecs[2].word, 50, ok);
    check("mr_accept0", ok, 1);
    push_word(vecs[3].word, 50, ok);
    check("mr_accept1", ok, 1);
    wait_rx(8, 500, "mr_wait");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mr_tx_load",    bus_if.tx_load,    0);
    check("mr_busy",       bus_if.busy,       0);
    check("mr_word_ready", bus_if.word_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("mr_post_word_ready", bus_if.word_ready, 1);
    check("mr_post_tx_load",    bus_if.tx_load,    0);
    repeat (4) @(negedge clk);
    clear_rx();
    push_word(vecs[4].word, 50, ok);
    check("mr_accept2", ok, 1);
    push_word(vecs[5].word, 50, ok);
    check("mr_accept3", ok, 1);
    build_exp(4, 5, 0);
    wait_rx(exp_q.size(), 2000, "mr_wait2");
    repeat (4) @(negedge clk);
    check_rx("mr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
